mul_seq_32: RTL and testbench

Multi-cycle unsigned 32×32→64 shift-add multiplier sequencer. Owns one instance of the team's 32-bit carry-lookahead adder (CLA_32) and steps it once per cycle over 32 iterations. It sits beside the ALU as the multi-cycle MUL unit: the CPU control raises `start` with operands and stalls on `busy` until `done`.

---
 rtl/mul_pkg.sv | 14 +
 rtl/cla_32.sv | 50 +++++
 rtl/mul_seq_32.sv | 87 ++++++++
 tb/tb_mul_seq_32.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared constants and state type for the sequential shift-add multiplier.
package mul_pkg;

    localparam int unsigned MUL_W    = 32;
    localparam int unsigned MUL_ITER = 32;
    localparam int unsigned CNT_W    = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_t;

endpackage

// File: rtl/cla_32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module cla_32 (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);

    localparam int unsigned W      = 32;
    localparam int unsigned GRP    = 4;
    localparam int unsigned NGRP   = W / GRP;

    logic [W-1:0]    g;
    logic [W-1:0]    p;
    logic [W:0]      c;
    logic [NGRP-1:0] gg;
    logic [NGRP-1:0] gp;
    logic [NGRP:0]   bc;

    always_comb begin
        g  = x & y;
        p  = x ^ y;
        gg = '0;
        gp = '1;
        bc = '0;
        c  = '0;
        // Group generate/propagate, then carry into each group.
        for (int b = 0; b < int'(NGRP); b++) begin
            for (int i = 0; i < int'(GRP); i++) begin
                gg[b] = g[b*GRP+i] | (p[b*GRP+i] & gg[b]);
                gp[b] = gp[b] & p[b*GRP+i];
            end
        end
        bc[0] = cin;
        for (int b = 0; b < int'(NGRP); b++) begin
            bc[b+1] = gg[b] | (gp[b] & bc[b]);
        end
        for (int b = 0; b < int'(NGRP); b++) begin
            c[b*GRP] = bc[b];
            for (int i = 0; i < int'(GRP) - 1; i++) begin
                c[b*GRP+i+1] = g[b*GRP+i] | (p[b*GRP+i] & c[b*GRP+i]);
            end
        end
        c[W] = bc[NGRP];
        s    = p ^ c[W-1:0];
        cout = c[W];
    end

endmodule

// File: rtl/mul_seq_32.sv
// Multi-cycle unsigned 32x32->64 shift-add multiplier; one CLA_32 step per cycle.
module mul_seq_32
    import mul_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [MUL_W-1:0]     mcand,
    input  logic [MUL_W-1:0]     mplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*MUL_W-1:0]   prod
);

    mul_state_t       state;
    logic [MUL_W-1:0] mcand_r;
    logic [MUL_W-1:0] p_hi;
    logic [MUL_W-1:0] p_lo;
    logic [CNT_W-1:0] cnt;
    logic [MUL_W-1:0] sum;
    logic             carry;
    logic             accept;

    cla_32 u_cla (
        .x    (p_hi),
        .y    (mcand_r),
        .cin  (1'b0),
        .s    (sum),
        .cout (carry)
    );

    // start is only honoured outside RUN; an operation is never restarted.
    always_comb begin
        accept = start && (state != RUN);
    end

    assign prod = {p_hi, p_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mcand_r <= '0;
            p_hi    <= '0;
            p_lo    <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (accept) begin
            mcand_r <= mcand;
            p_hi    <= '0;
            p_lo    <= mplier;
            cnt     <= '0;
            state   <= RUN;
            busy    <= 1'b1;
            done    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    // Adder carry-out becomes the top bit of the shifted partial product.
                    if (p_lo[0]) begin
                        p_hi <= {carry, sum[MUL_W-1:1]};
                        p_lo <= {sum[0], p_lo[MUL_W-1:1]};
                    end else begin
                        p_hi <= {1'b0, p_hi[MUL_W-1:1]};
                        p_lo <= {p_hi[0], p_lo[MUL_W-1:1]};
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(MUL_ITER - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_32.sv
// Scoreboard bench for mul_seq_32: directed operands, expected products queued at issue.
module tb_mul_seq_32;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        busy;
    logic        done;
    logic [63:0] prod;

    typedef struct {
        logic [63:0] prod;
        int          e0;
    } exp_t;

    exp_t q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   n_push  = 0;
    int   n_done  = 0;

    mul_seq_32 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mcand  (mcand),
        .mplier (mplier),
        .busy   (busy),
        .done   (done),
        .prod   (prod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Issue one operation; the posedge after setting start is the accepting edge E0.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] expv, input bit track);
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        @(posedge clk);
        #1;
        if (track) begin
            e.prod = expv;
            e.e0   = cyc;
            q.push_back(e);
            n_push++;
        end
        start  = 1'b0;
        mcand  = $urandom;
        mplier = $urandom;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    initial begin
        int          busy_run;
        bit          hold_chk;
        logic [63:0] last_prod;
        exp_t        e;
        busy_run  = 0;
        hold_chk  = 1'b0;
        last_prod = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_run = 0;
                hold_chk = 1'b0;
            end else begin
                if (hold_chk) begin
                    hold_chk = 1'b0;
                    if (!busy) chk("prod_hold", prod, last_prod);
                end
                if (busy) busy_run++;
                if (done) begin
                    n_done++;
                    chk("busy_with_done", 64'(busy), 64'd0);
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got prod %h expected no done", prod);
                    end else begin
                        e = q.pop_front();
                        chk("prod", prod, e.prod);
                        chk("latency", 64'(cyc - e.e0), 64'd32);
                        chk("busy_cycles", 64'(busy_run), 64'd32);
                    end
                    busy_run  = 0;
                    last_prod = prod;
                    hold_chk  = 1'b1;
                end
            end
        end
    end

    initial begin
        exp_t e;
        rst_n  = 1'b0;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_prod", prod, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        issue(32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b1);
        wait_drain();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
        wait_drain();
        issue(32'h1234_5678, 32'd0, 64'd0, 1'b1);
        wait_drain();
        issue(32'd0, 32'h1234_5678, 64'd0, 1'b1);
        wait_drain();

        // start with new operands during RUN must be ignored.
        issue(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        start  = 1'b1;
        mcand  = 32'd5;
        mplier = 32'd5;
        @(negedge clk);
        start  = 1'b0;
        wait_drain();

        // Back-to-back: start held through DONE.
        issue(32'd7, 32'd9, 64'd63, 1'b1);
        start  = 1'b1;
        mcand  = 32'h8000_0000;
        mplier = 32'd2;
        repeat (32) @(posedge clk);
        @(posedge clk);
        #1;
        e.prod = 64'h0000_0001_0000_0000;
        e.e0   = cyc;
        q.push_back(e);
        n_push++;
        start = 1'b0;
        wait_drain();

        // Asynchronous reset mid-operation discards the result.
        issue(32'hABCD_0123, 32'h1234_FFFF, 64'd0, 1'b0);
        repeat (16) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_prod", prod, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        issue(32'd6, 32'd7, 64'd42, 1'b1);
        wait_drain();

        chk("done_count", 64'(n_done), 64'(n_push));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
